// File: rtl/branch_predict_resolve_unit.sv
// Branch resolve unit with a PC-indexed 2-bit counter table for fetch prediction.
// Optional BPU_STATS_EN adds saturating branch/mispredict statistics counters.
module branch_predict_resolve_unit #(
    parameter int          XLEN      = 32,
    parameter int          BHT_DEPTH = 64,
    parameter logic [1:0]  INIT_CTR  = 2'b01
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            predict_taken_o,
    output logic            ready_o,
    input  logic            res_valid_i,
    input  logic [XLEN-1:0] res_pc_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic [3:0]      select_i,
    input  logic            res_pred_taken_i,
    output logic            pc_mux_out_o,
    output logic            mispredict_o,
    output logic            res_done_o
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispredicts_o
`endif
);

    localparam int IDXW = $clog2(BHT_DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [1:0]      bht_q [BHT_DEPTH];

    logic [IDXW-1:0] fetchIdx, resIdx, bhtWIdx;
    logic [1:0]      bhtWData, resCtr;
    logic            bhtWe;
    logic [2:0]      code;
    logic            isCtrl, isCond, resTaken, resMispred;
    logic            pc_mux_q, mispredict_q, res_done_q;
    logic            unusedPcBits;

    assign fetchIdx     = fetch_pc_i[IDXW+1:2];
    assign resIdx       = res_pc_i[IDXW+1:2];
    assign unusedPcBits = ^{fetch_pc_i[XLEN-1:IDXW+2], fetch_pc_i[1:0],
                            res_pc_i[XLEN-1:IDXW+2], res_pc_i[1:0]};
    assign code         = select_i[2:0];
    assign isCtrl       = select_i[3] && (code != 3'b011);
    assign isCond       = isCtrl && (code != 3'b010);
    assign resCtr       = bht_q[resIdx];

    always_comb begin
        resTaken = 1'b0;
        if (select_i[3]) begin
            case (code)
                3'b000:  resTaken = (data1_i == data2_i);
                3'b001:  resTaken = (data1_i != data2_i);
                3'b100:  resTaken = ($signed(data1_i) <  $signed(data2_i));
                3'b101:  resTaken = ($signed(data1_i) >= $signed(data2_i));
                3'b110:  resTaken = (data1_i <  data2_i);
                3'b111:  resTaken = (data1_i >= data2_i);
                3'b010:  resTaken = 1'b1;
                default: resTaken = 1'b0;
            endcase
        end
    end

    assign resMispred = res_valid_i && isCtrl && (resTaken != res_pred_taken_i);

    // Init sweeps the table one entry per cycle; training only happens once running.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        bhtWe    = 1'b0;
        bhtWIdx  = ptr_q;
        bhtWData = INIT_CTR;
        case (state_q)
            ST_INIT: begin
                bhtWe = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == IDXW'(BHT_DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (res_valid_i && isCond) begin
                    bhtWe   = 1'b1;
                    bhtWIdx = resIdx;
                    if (resTaken) begin
                        bhtWData = (resCtr == 2'b11) ? 2'b11 : resCtr + 2'b01;
                    end else begin
                        bhtWData = (resCtr == 2'b00) ? 2'b00 : resCtr - 2'b01;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            pc_mux_q     <= 1'b0;
            mispredict_q <= 1'b0;
            res_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pc_mux_q     <= res_valid_i && resTaken;
            mispredict_q <= resMispred;
            res_done_q   <= res_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (bhtWe) begin
            bht_q[bhtWIdx] <= bhtWData;
        end
    end

    assign ready_o         = (state_q == ST_RUN);
    assign predict_taken_o = ready_o && bht_q[fetchIdx][1];
    assign pc_mux_out_o    = pc_mux_q;
    assign mispredict_o    = mispredict_q;
    assign res_done_o      = res_done_q;

`ifdef BPU_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (res_valid_i && isCtrl && (stat_br_q != 32'hFFFF_FFFF)) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (resMispred && (stat_mp_q != 32'hFFFF_FFFF)) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches_o    = stat_br_q;
    assign stat_mispredicts_o = stat_mp_q;
`endif

endmodule
